// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/nbit_adder.sv
// Parametrised ripple-carry adder; one instance serves every multiply iteration.
module nbit_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH iterations per product, signed or unsigned.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned PW   = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    // Upper half accumulates partial sums; lower half starts as the multiplier and
    // is shifted out one bit per iteration as product bits shift in.
    logic [PW-1:0]    acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic [PW-1:0]    acc_shift;
    logic [PW-1:0]    acc_neg;

    // -2^(W-1) negates to 2^(W-1), which is still representable as W-bit unsigned.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    assign addend = acc_q[0] ? mcand_q : '0;

    nbit_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q[PW-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (sum_cout)
    );

    assign acc_shift = {sum_cout, sum, acc_q[WIDTH-1:1]};
    assign acc_neg   = ~acc_shift + PW'(1);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    cnt_d   = '0;
                    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d  = acc_shift;
                cnt_d  = cnt_q + CntW'(1);
                busy_d = 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    product_d = neg_q ? acc_neg : acc_shift;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier with a start/busy/done handshake and a selectable signed (two's-complement) or unsigned mode. It is the next generation of the team's fixed 4×4 combinational array multiplier. One W-bit adder is reused over WIDTH cycles instead of a full adder array. It sits as an arithmetic slave behind a controller that issues one multiply at a time.

## Interface
- WIDTH, default 8: operand width in bits, at least 2; the product is 2*WIDTH bits.
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: request a multiply; sampled only in IDLE or DONE.
- signed_mode  in  1: 1 = operands and product are two's-complement, 0 = unsigned; sampled with start.
- a  in  WIDTH: multiplicand; sampled with start.
- b  in  WIDTH: multiplier; sampled with start.
- busy  out  1: high while a multiply is in progress.
- done  out  1: one-cycle pulse marking that product holds a new result.
- product  out  2*WIDTH: result; holds its value until the next done.

## Operation
- States are IDLE, CALC and DONE.
- Reset values: state = IDLE, busy = 0, done = 0, product = 0, internal registers = 0.
- IDLE or DONE with start = 1:
  - Latch the magnitudes |a| and |b|. In unsigned mode the operands are used as-is.
  - Latch neg = signed_mode & (a[W-1] ^ b[W-1]).
  - Clear the accumulator and iteration counter, then go to CALC.
- start is ignored in CALC. Operand changes during CALC have no effect.
- CALC, one iteration per cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper W bits of the accumulator with a (W+1)-bit sum.
  - Shift the accumulator right by 1, shifting in the carry.
  - Shift the multiplier right by 1 and increment the counter.
- After iteration WIDTH:
  - product <= neg ? -acc : acc, using a 2W-bit two's-complement negate.
  - Go to DONE.
- DONE: done = 1 for that cycle only. Without start, the next state is IDLE. With start, a new multiply begins (back-to-back).
- Width rules:
  - Magnitudes are W-bit unsigned. The case -2^(W-1) gives magnitude 2^(W-1), which fits.
  - The accumulator is 2W bits and never overflows.
  - The signed product always fits in 2W bits. For example, (-2^(W-1))² = 2^(2W-2).
- A zero operand still takes the full WIDTH iterations; there is no early termination.
- rst_n asserted at any time, including mid-CALC, returns to reset values immediately. No done is issued for the aborted operation.

## Timing
- Edge k samples start = 1: busy goes high after edge k.
- Edges k+1 .. k+WIDTH perform the WIDTH iterations.
- At edge k+WIDTH: product is updated, busy drops and done rises.
- done is high for exactly one cycle, from edge k+WIDTH to edge k+WIDTH+1.
- Latency from the start-sampling edge to the product update is WIDTH edges.
- Throughput is one result per WIDTH+1 cycles when start is held high.
- busy and done are never high together. Both come directly from registers; there is no combinational path from inputs to outputs.
- product is stable from done until the next done, even across start and CALC.

## Structure
- Package mult_pkg holds:
  - the state enum state_t {IDLE, CALC, DONE};
  - the localparam default width DEF_WIDTH = 8.
- Counter width is $clog2(WIDTH+1), computed in the module.
- One sub-module, nbit_adder:
  - parametrised WIDTH-bit ripple-carry adder with cin, S and Cout;
  - the generalised successor of the team's 4-bit adder;
  - instantiated once for the iteration add.
- The final negate uses an inline 2W-bit expression, not a second adder instance.

## Test plan
All scenarios use WIDTH = 8.
- Unsigned, a = 255, b = 255, start for one cycle -> product = 0xFE01 (65025). done pulses exactly 8 edges after the start edge. busy is high for 8 cycles.
- Signed, a = 0xF9 (-7), b = 0x06 -> product = 0xFFD6 (-42). Then a = 0x80, b = 0x80 -> product = 0x4000 (16384). Then a = 0x80, b = 0x7F -> product = 0xC080 (-16256).
- Unsigned 0x80 × 0x80 -> product = 0x4000. Zero operand, a = 0, b = 0xAB -> product = 0 after the full 8-cycle latency.
- start held high for 30 cycles with a = 3, b = 5 -> done pulses every 9 cycles, each with product = 15. start pulses in CALC are ignored; changing a in CALC does not change the result.
- rst_n pulled low at CALC iteration 4 -> busy = 0, done = 0 and product = 0 asynchronously. No done follows. The next start after reset gives a correct result.
- Product hold: after a result of 15, a new start with 2×2 -> product stays 15 until the next done edge, then becomes 4.
